// File: rtl/threshold_table_loader.sv
// Fills the comparator threshold RAM with sat(floor(c * M / 2^FRAC_BITS)) for c = 0..VECTOR_WIDTH.
// Latency: first write 2 cycles after start (plus drain wait), o_Done 3+D+VECTOR_WIDTH cycles after start.
// Backpressure: holds the comparator pipeline via o_PipeHold from start until the cycle after o_Done.
module threshold_table_loader #(
   parameter int VECTOR_WIDTH = 920,
   parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH),
   parameter int MULT_WIDTH   = 16,
   parameter int FRAC_BITS    = 12
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  i_Start,
   input  logic [MULT_WIDTH-1:0] i_Mult,
   input  logic                  i_PipeIdle,
   output logic                  o_PipeHold,
   output logic                  o_Busy,
   output logic                  o_Done,
   output logic                  o_Loaded,
   output logic [CNT_WIDTH-1:0]  o_BRAM_Addr,
   output logic [CNT_WIDTH-1:0]  o_BRAM_Din,
   output logic                  o_BRAM_En,
   output logic                  o_BRAM_WrEn
);

   // Accumulator sized so c * M never wraps for any c <= VECTOR_WIDTH.
   localparam int ACC_W = CNT_WIDTH + MULT_WIDTH + 1;
   // Entry counter carries one extra bit so it can reach VECTOR_WIDTH+1.
   localparam logic [CNT_WIDTH:0] END_CNT = (CNT_WIDTH+1)'(VECTOR_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [MULT_WIDTH-1:0]  mult_q;
   logic [ACC_W-1:0]       acc;
   logic [CNT_WIDTH:0]     cnt;
   logic                   start_acc;

   logic                   busy_d;
   logic                   done_d;
   logic                   wr_d;
   logic [CNT_WIDTH-1:0]   addr_d;
   logic [CNT_WIDTH-1:0]   din_d;

   // A start request only counts while idle; it is never queued.
   assign start_acc = (state == S_IDLE) && i_Start;

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (i_Start) state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (i_PipeIdle) state_next = S_WRITE;
         end
         S_WRITE: begin
            // cnt has already moved past the last address once VECTOR_WIDTH was written.
            if (cnt == END_CNT) state_next = S_DONE;
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Output decode from the next state so every port comes straight from a flop.
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      wr_d   = 1'b0;
      addr_d = '0;
      din_d  = '0;
      busy_d = (state_next != S_IDLE);
      done_d = (state_next == S_DONE);
      if (state_next == S_WRITE) begin
         wr_d   = 1'b1;
         addr_d = cnt[CNT_WIDTH-1:0];
         // Any integer-part bit above the table data width means the entry saturates.
         if (|acc[ACC_W-1:FRAC_BITS+CNT_WIDTH]) begin
            din_d = '1;
         end else begin
            din_d = acc[FRAC_BITS+CNT_WIDTH-1:FRAC_BITS];
         end
      end
   end

   // Multiplier latch, accumulator and entry counter; entries are built by repeated addition.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mult_q <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (start_acc) begin
         mult_q <= i_Mult;
         acc    <= '0;
         cnt    <= '0;
      end else if (state_next == S_WRITE) begin
         acc <= acc + ACC_W'(mult_q);
         cnt <= cnt + 1'b1;
      end
   end

   // Loaded flag: cleared when a new load is accepted, set as the load completes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_Loaded <= 1'b0;
      end else if (start_acc) begin
         o_Loaded <= 1'b0;
      end else if (state_next == S_DONE) begin
         o_Loaded <= 1'b1;
      end
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_Busy      <= 1'b0;
         o_PipeHold  <= 1'b0;
         o_Done      <= 1'b0;
         o_BRAM_En   <= 1'b0;
         o_BRAM_WrEn <= 1'b0;
         o_BRAM_Addr <= '0;
         o_BRAM_Din  <= '0;
      end else begin
         o_Busy      <= busy_d;
         o_PipeHold  <= busy_d;
         o_Done      <= done_d;
         o_BRAM_En   <= wr_d;
         o_BRAM_WrEn <= wr_d;
         o_BRAM_Addr <= addr_d;
         o_BRAM_Din  <= din_d;
      end
   end

endmodule

// File: tb/tb_threshold_table_loader.sv
// Bench for threshold_table_loader: directed loads with hand-computed table entries.
// Latency: checks write cycles, o_Done cycle and hold release relative to the start edge.
// Backpressure: drives i_PipeIdle low for a few cycles to exercise the drain wait.
module tb_threshold_table_loader;

   localparam int VW = 920;
   localparam int CW = 10;
   localparam int MW = 16;

   logic          clk;
   logic          rstn;
   logic          i_Start;
   logic [MW-1:0] i_Mult;
   logic          i_PipeIdle;
   logic          o_PipeHold;
   logic          o_Busy;
   logic          o_Done;
   logic          o_Loaded;
   logic [CW-1:0] o_BRAM_Addr;
   logic [CW-1:0] o_BRAM_Din;
   logic          o_BRAM_En;
   logic          o_BRAM_WrEn;

   threshold_table_loader dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_Start     (i_Start),
      .i_Mult      (i_Mult),
      .i_PipeIdle  (i_PipeIdle),
      .o_PipeHold  (o_PipeHold),
      .o_Busy      (o_Busy),
      .o_Done      (o_Done),
      .o_Loaded    (o_Loaded),
      .o_BRAM_Addr (o_BRAM_Addr),
      .o_BRAM_Din  (o_BRAM_Din),
      .o_BRAM_En   (o_BRAM_En),
      .o_BRAM_WrEn (o_BRAM_WrEn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [25:0] outs;
   assign outs = {o_Busy, o_PipeHold, o_Done, o_Loaded, o_BRAM_En, o_BRAM_WrEn, o_BRAM_Addr, o_BRAM_Din};

   int total;
   int bad;

   // Results of the most recent load.
   int mem [0:VW];
   int wr_cnt, done_cnt, done_cyc, first_cyc, first_addr;
   int addr_err, hold_err, tbl_err;
   int loaded_k1, loaded_after, hold_after, busy_after;
   logic [25:0] abort_outs;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_entry(input int c, input int m);
      longint p;
      p = (longint'(c) * longint'(m)) >>> 12;
      if (p > 1023) p = 1023;
      return int'(p);
   endfunction

   // One load: start with multiplier m, keep i_PipeIdle low for d extra cycles,
   // optionally pulse a second start at address 100, optionally reset at abort_at.
   task automatic run_load(input int m, input int d, input bit glitch, input int abort_at);
      int exp_addr;
      bit clr_start;
      for (int c = 0; c <= VW; c++) mem[c] = -1;
      wr_cnt = 0; done_cnt = 0; done_cyc = -1; first_cyc = -1; first_addr = -1;
      addr_err = 0; hold_err = 0; loaded_k1 = -1; loaded_after = -1;
      hold_after = -1; busy_after = -1; exp_addr = 0; clr_start = 0;
      @(negedge clk);
      i_Start = 1'b1;
      i_Mult = MW'(m);
      i_PipeIdle = (d == 0);
      @(posedge clk);
      #1 i_Start = 1'b0;
      for (int k = 1; k < 1100; k++) begin
         @(negedge clk);
         if (clr_start) begin
            i_Start = 1'b0;
            i_Mult = MW'(m);
            clr_start = 0;
         end
         i_PipeIdle = (k >= 1 + d);
         if (k == 1) loaded_k1 = int'(o_Loaded);
         if (o_Busy !== o_PipeHold) hold_err++;
         if (k <= 1 + d && (o_PipeHold !== 1'b1 || o_BRAM_En || o_BRAM_WrEn)) hold_err++;
         if (o_BRAM_En && o_BRAM_WrEn) begin
            if (first_cyc < 0) begin
               first_cyc = k;
               first_addr = int'(o_BRAM_Addr);
            end
            if (int'(o_BRAM_Addr) != exp_addr) addr_err++;
            exp_addr++;
            mem[o_BRAM_Addr] = int'(o_BRAM_Din);
            wr_cnt++;
            if (glitch && o_BRAM_Addr == 10'd100) begin
               i_Start = 1'b1;
               i_Mult = 16'h2800;
               clr_start = 1;
            end
            if (abort_at >= 0 && int'(o_BRAM_Addr) == abort_at) begin
               rstn = 1'b0;
               #1 abort_outs = outs;
               break;
            end
         end
         if (o_Done) begin
            done_cnt++;
            done_cyc = k;
         end
         if (done_cyc > 0 && k == done_cyc + 1) begin
            hold_after = int'(o_PipeHold);
            busy_after = int'(o_Busy);
            loaded_after = int'(o_Loaded);
         end
         if (done_cyc > 0 && k == done_cyc + 2) break;
      end
   endtask

   task automatic check_table(input int m);
      tbl_err = 0;
      for (int c = 0; c <= VW; c++)
         if (mem[c] != ref_entry(c, m)) tbl_err++;
   endtask

   initial begin
      total = 0;
      bad = 0;
      rstn = 1'b0;
      i_Start = 1'b0;
      i_Mult = '0;
      i_PipeIdle = 1'b1;
      #13;
      chk("reset_outs", 32'(outs), 0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("idle_outs", 32'(outs), 0);

      // M = 1.0, no drain wait
      run_load(32'h1000, 0, 0, -1);
      check_table(32'h1000);
      chk("m1_writes", wr_cnt, 921);
      chk("m1_table", tbl_err, 0);
      chk("m1_e500", mem[500], 500);
      chk("m1_addr_seq", addr_err, 0);
      chk("m1_first_cyc", first_cyc, 2);
      chk("m1_done_cnt", done_cnt, 1);
      chk("m1_done_cyc", done_cyc, 923);
      chk("m1_hold", hold_err, 0);
      chk("m1_hold_after", hold_after, 0);
      chk("m1_busy_after", busy_after, 0);
      chk("m1_loaded", loaded_after, 1);

      // M = 2.5, saturation near the top of the table
      run_load(32'h2800, 0, 0, -1);
      check_table(32'h2800);
      chk("m25_loaded_cleared", loaded_k1, 0);
      chk("m25_e408", mem[408], 1020);
      chk("m25_e409", mem[409], 1022);
      chk("m25_e410", mem[410], 1023);
      chk("m25_e920", mem[920], 1023);
      chk("m25_table", tbl_err, 0);

      // M = 0
      run_load(0, 0, 0, -1);
      check_table(0);
      chk("m0_table", tbl_err, 0);
      chk("m0_e920", mem[920], 0);
      chk("m0_writes", wr_cnt, 921);

      // M = 0.5
      run_load(32'h0800, 0, 0, -1);
      check_table(32'h0800);
      chk("m05_e7", mem[7], 3);
      chk("m05_e920", mem[920], 460);
      chk("m05_table", tbl_err, 0);

      // Pipeline busy for 5 cycles after start
      run_load(32'h1000, 5, 0, -1);
      chk("drain_hold", hold_err, 0);
      chk("drain_first_cyc", first_cyc, 7);
      chk("drain_first_addr", first_addr, 0);
      chk("drain_done_cyc", done_cyc, 928);
      chk("drain_writes", wr_cnt, 921);

      // Second start during WRITE is ignored
      run_load(32'h1000, 0, 1, -1);
      check_table(32'h1000);
      chk("glitch_table", tbl_err, 0);
      chk("glitch_e920", mem[920], 920);
      chk("glitch_done_cnt", done_cnt, 1);
      chk("glitch_writes", wr_cnt, 921);
      repeat (3) @(negedge clk);
      chk("glitch_no_restart", {31'd0, o_Busy}, 0);

      // Reset at address 300
      run_load(32'h1000, 0, 0, 300);
      chk("abort_outs", 32'(abort_outs), 0);
      chk("abort_writes", wr_cnt, 301);
      repeat (2) @(negedge clk);
      chk("abort_held_outs", 32'(outs), 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("abort_loaded", {31'd0, o_Loaded}, 0);
      run_load(32'h1000, 0, 0, -1);
      check_table(32'h1000);
      chk("reload_writes", wr_cnt, 921);
      chk("reload_table", tbl_err, 0);
      chk("reload_done_cnt", done_cnt, 1);
      chk("reload_loaded", loaded_after, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
